// File: rtl/prog_mem_if.sv
// Fetch and loader bundle between the 4-bit CPU/host and prog_mem.
// master = CPU + host side, slave = program memory.
interface prog_mem_if;
  logic [3:0] addr;
  logic [3:0] opecode;
  logic [3:0] imm;
  logic       cpu_n_rst;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       run;
  logic       load_done;
  logic [7:0] checksum;
  logic [1:0] state_o;

  modport master (
    output addr,
    output load_start,
    output load_valid,
    output load_data,
    output run,
    input  opecode,
    input  imm,
    input  cpu_n_rst,
    input  load_ready,
    input  load_done,
    input  checksum,
    input  state_o
  );

  modport slave (
    input  addr,
    input  load_start,
    input  load_valid,
    input  load_data,
    input  run,
    output opecode,
    output imm,
    output cpu_n_rst,
    output load_ready,
    output load_done,
    output checksum,
    output state_o
  );
endinterface

// File: rtl/prog_mem.sv
// 16x8 program memory with byte-wise loader and a mode FSM
// that holds the CPU in reset until a program is present.
module prog_mem #(
  parameter int DEPTH = 16
) (
  input logic       clk,
  input logic       rst,
  prog_mem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int AW = 4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic [7:0]    sum_q;
  logic          done_q;
  logic [7:0]    mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.load_start) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            sum_q   <= '0;
          end else if (bus.run) begin
            state_q <= RUN;
          end
        end
        LOAD: begin
          // a restart drops whatever word is offered in the same cycle
          if (bus.load_start) begin
            ptr_q <= '0;
            sum_q <= '0;
          end else if (bus.load_valid) begin
            mem_q[ptr_q] <= bus.load_data;
            sum_q        <= sum_q + bus.load_data;
            if (ptr_q == LAST) begin
              state_q <= RUN;
              done_q  <= 1'b1;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.load_start) begin
            state_q <= LOAD;
            ptr_q   <= '0;
            sum_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign {bus.opecode, bus.imm} = mem_q[bus.addr];
  assign bus.load_ready = (state_q == LOAD);
  assign bus.cpu_n_rst  = (state_q == RUN);
  assign bus.state_o    = state_q;
  assign bus.load_done  = done_q;
  assign bus.checksum   = sum_q;

endmodule

// File: tb/tb_prog_mem.sv
// Randomised bench for prog_mem against an array-based model
// of program contents, load pointer and running checksum.
module tb_prog_mem;

  logic clk;
  logic rst;

  prog_mem_if bus ();

  prog_mem #(.DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [7:0] exp_mem [16];
  int         exp_ptr;
  logic [7:0] exp_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    exp_ptr = 0;
    exp_sum = 8'h00;
  endtask

  task automatic model_session();
    exp_ptr = 0;
    exp_sum = 8'h00;
  endtask

  task automatic model_accept(input logic [7:0] w);
    exp_mem[exp_ptr] = w;
    exp_ptr = exp_ptr + 1;
    exp_sum = exp_sum + w;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.run        = 1'b0;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    model_session();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.addr = 4'd5;
    tick();
    tick();
    model_clear();
    vecs++;
    if ({bus.opecode, bus.imm} !== 8'h00) begin
      errs++;
      $display("FAIL reset_word got %h want 00",
               {bus.opecode, bus.imm});
    end
    vecs++;
    if (bus.cpu_n_rst !== 1'b0 || bus.load_ready !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl got n_rst=%b rdy=%b want 0 0",
               bus.cpu_n_rst, bus.load_ready);
    end
    vecs++;
    if (bus.checksum !== 8'h00 || bus.state_o !== 2'd0) begin
      errs++;
      $display("FAIL reset_state got sum=%h st=%0d want 00 0",
               bus.checksum, bus.state_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    logic [7:0] w;
    pulse_start();
    vecs++;
    if (bus.state_o !== 2'd1 || bus.load_ready !== 1'b1
        || bus.checksum !== 8'h00) begin
      errs++;
      $display("FAIL full_enter got st=%0d rdy=%b sum=%h want 1 1 00",
               bus.state_o, bus.load_ready, bus.checksum);
    end
    for (int i = 0; i < 16; i++) begin
      w = (i == 0) ? 8'h31 : (i == 15) ? 8'hF0 : 8'($urandom);
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      bus.addr       = 4'(i);
      tick();
      model_accept(w);
      vecs++;
      if ({bus.opecode, bus.imm} !== w) begin
        errs++;
        $display("FAIL full_latency addr=%0d got %h want %h",
                 i, {bus.opecode, bus.imm}, w);
      end
      vecs++;
      if (bus.load_done !== (i == 15)) begin
        errs++;
        $display("FAIL full_done idx=%0d got %b want %b",
                 i, bus.load_done, (i == 15));
      end
    end
    bus.load_valid = 1'b0;
    vecs++;
    if (bus.state_o !== 2'd2 || bus.cpu_n_rst !== 1'b1
        || bus.load_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_run got st=%0d n_rst=%b rdy=%b want 2 1 0",
               bus.state_o, bus.cpu_n_rst, bus.load_ready);
    end
    vecs++;
    if (bus.checksum !== exp_sum) begin
      errs++;
      $display("FAIL full_sum got %h want %h", bus.checksum, exp_sum);
    end
    tick();
    vecs++;
    if (bus.load_done !== 1'b0) begin
      errs++;
      $display("FAIL full_done_len got %b want 0", bus.load_done);
    end
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      vecs++;
      if ({bus.opecode, bus.imm} !== exp_mem[a]) begin
        errs++;
        $display("FAIL full_sweep addr=%0d got %h want %h",
                 a, {bus.opecode, bus.imm}, exp_mem[a]);
      end
    end
  endtask

  task automatic test_gapped_load();
    int acc = 0;
    int cyc = 0;
    int pulses = 0;
    logic v;
    logic [7:0] w;
    pulse_start();
    while (acc < 16 && cyc < 64) begin
      v = (cyc % 2 == 0);
      w = 8'($urandom);
      bus.load_valid = v;
      bus.load_data  = w;
      tick();
      if (v) begin
        model_accept(w);
        acc++;
      end
      if (bus.load_done === 1'b1) pulses++;
      vecs++;
      if (bus.checksum !== exp_sum) begin
        errs++;
        $display("FAIL gap_sum cyc=%0d got %h want %h",
                 cyc, bus.checksum, exp_sum);
      end
      cyc++;
    end
    bus.load_valid = 1'b0;
    vecs++;
    if (acc != 16) begin
      errs++;
      $display("FAIL gap_timeout got %0d accepts want 16", acc);
    end
    vecs++;
    if (pulses != 1 || bus.state_o !== 2'd2) begin
      errs++;
      $display("FAIL gap_done got pulses=%0d st=%0d want 1 2",
               pulses, bus.state_o);
    end
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      vecs++;
      if ({bus.opecode, bus.imm} !== exp_mem[a]) begin
        errs++;
        $display("FAIL gap_sweep addr=%0d got %h want %h",
                 a, {bus.opecode, bus.imm}, exp_mem[a]);
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] w;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom);
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      tick();
      model_accept(w);
    end
    bus.load_start = 1'b1;
    bus.load_data  = 8'hAA;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    model_session();
    vecs++;
    if (bus.checksum !== 8'h00 || bus.state_o !== 2'd1) begin
      errs++;
      $display("FAIL restart_sum got sum=%h st=%0d want 00 1",
               bus.checksum, bus.state_o);
    end
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      vecs++;
      if ({bus.opecode, bus.imm} !== exp_mem[a]) begin
        errs++;
        $display("FAIL restart_keep addr=%0d got %h want %h",
                 a, {bus.opecode, bus.imm}, exp_mem[a]);
      end
    end
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5C;
    tick();
    model_accept(8'h5C);
    bus.addr = 4'd0;
    #1;
    vecs++;
    if ({bus.opecode, bus.imm} !== 8'h5C || bus.checksum !== 8'h5C) begin
      errs++;
      $display("FAIL restart_first got %h sum=%h want 5c 5c",
               {bus.opecode, bus.imm}, bus.checksum);
    end
    for (int i = 1; i < 16; i++) begin
      w = 8'($urandom);
      bus.load_data = w;
      tick();
      model_accept(w);
    end
    bus.load_valid = 1'b0;
    vecs++;
    if (bus.state_o !== 2'd2 || bus.checksum !== exp_sum) begin
      errs++;
      $display("FAIL restart_end got st=%0d sum=%h want 2 %h",
               bus.state_o, bus.checksum, exp_sum);
    end
  endtask

  task automatic test_reload_from_run();
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h77;
    bus.addr       = 4'd0;
    tick();
    bus.load_valid = 1'b0;
    vecs++;
    if ({bus.opecode, bus.imm} !== exp_mem[0]
        || bus.checksum !== exp_sum) begin
      errs++;
      $display("FAIL run_ignore got %h sum=%h want %h %h",
               {bus.opecode, bus.imm}, bus.checksum, exp_mem[0], exp_sum);
    end
    pulse_start();
    vecs++;
    if (bus.cpu_n_rst !== 1'b0 || bus.state_o !== 2'd1
        || bus.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL reload got n_rst=%b st=%0d rdy=%b want 0 1 1",
               bus.cpu_n_rst, bus.state_o, bus.load_ready);
    end
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    vecs++;
    if (bus.state_o !== 2'd1) begin
      errs++;
      $display("FAIL load_run_ignore got st=%0d want 1", bus.state_o);
    end
  endtask

  task automatic test_run_priority();
    logic [7:0] w;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    vecs++;
    if (bus.cpu_n_rst !== 1'b1 || bus.state_o !== 2'd2) begin
      errs++;
      $display("FAIL run_idle got n_rst=%b st=%0d want 1 2",
               bus.cpu_n_rst, bus.state_o);
    end
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      vecs++;
      if ({bus.opecode, bus.imm} !== 8'h00) begin
        errs++;
        $display("FAIL run_empty addr=%0d got %h want 00",
                 a, {bus.opecode, bus.imm});
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.run        = 1'b1;
    bus.load_start = 1'b1;
    tick();
    idle_inputs();
    model_session();
    vecs++;
    if (bus.state_o !== 2'd1 || bus.cpu_n_rst !== 1'b0) begin
      errs++;
      $display("FAIL prio got st=%0d n_rst=%b want 1 0",
               bus.state_o, bus.cpu_n_rst);
    end
    for (int i = 0; i < 7; i++) begin
      w = 8'($urandom) | 8'h01;
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      tick();
      model_accept(w);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.load_valid = 1'b0;
    model_clear();
    vecs++;
    if (bus.state_o !== 2'd0 || bus.checksum !== 8'h00) begin
      errs++;
      $display("FAIL rst_mid got st=%0d sum=%h want 0 00",
               bus.state_o, bus.checksum);
    end
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      vecs++;
      if ({bus.opecode, bus.imm} !== exp_mem[a]) begin
        errs++;
        $display("FAIL rst_mid_sweep addr=%0d got %h want %h",
                 a, {bus.opecode, bus.imm}, exp_mem[a]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.addr = 4'd0;
    idle_inputs();
    test_reset();
    test_full_load();
    test_gapped_load();
    test_restart();
    test_reload_from_run();
    test_run_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Program memory and loader for the 4-bit CPU: the responder side of the CPU's instruction-fetch interface. It holds 16 instruction words of 8 bits each, `{opecode, imm}`. It returns the word selected by the CPU's `addr` every cycle. A byte-wise valid/ready load port lets a host or test fixture write the whole program. A mode FSM holds the CPU in reset while the program is absent or being loaded, and releases it once loading completes.

## Interface
Parameters:
- DEPTH, 16: number of instruction words; fixed to match the 4-bit `addr`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  4  fetch address from the CPU.
- opecode  out  4  upper nibble of `mem[addr]`.
- imm  out  4  lower nibble of `mem[addr]`.
- cpu_n_rst  out  1  active-low reset to the CPU; high only in RUN.
- load_start  in  1  one-cycle request to begin or restart a load session.
- load_valid  in  1  `load_data` is valid this cycle.
- load_data  in  8  instruction word `{opecode, imm}`.
- load_ready  out  1  loader accepts a word this cycle.
- run  in  1  one-cycle request to start the CPU with the current contents.
- load_done  out  1  one-cycle pulse when the 16th word is accepted.
- checksum  out  8  sum mod 256 of all words accepted in the current or last session.
- state_o  out  2  current FSM state: 0 = IDLE, 1 = LOAD, 2 = RUN.

## Operation
- Storage is a 16x8 array of flops. `rst` clears every word to 0x00, meaning "ADD A,0".
- The read port is combinational: `{opecode, imm} = mem[addr]` in every state, including during load.
- FSM states:
  - IDLE (reset state): `cpu_n_rst`=0, `load_ready`=0.
    - `load_start` moves to LOAD.
    - Otherwise `run` moves to RUN.
    - If both are high, `load_start` wins.
  - LOAD: `load_ready`=1, `cpu_n_rst`=0.
    - A word is accepted when `load_valid & load_ready`. It is written to `mem[ptr]`; `ptr` increments and `checksum` adds the word.
    - Accepting the word while `ptr`=15 writes entry 15, pulses `load_done`, and moves to RUN.
    - `run` is ignored in LOAD.
    - `load_start` in LOAD restarts the session: `ptr`=0, `checksum`=0, and any word presented that cycle is dropped (not written, not summed). Earlier-written entries keep their values until overwritten.
  - RUN: `cpu_n_rst`=1, `load_ready`=0. `load_valid` is ignored.
    - `load_start` moves to LOAD and drops `cpu_n_rst` to 0, which aborts the CPU.
- Entering LOAD from IDLE or RUN sets `ptr`=0 and `checksum`=0.
- `ptr` is 4 bits and wraps 15→0 only through a state exit; no write beyond entry 15 is possible.
- `checksum` addition is 8-bit, with carry discarded.

## Timing
- Reset values: `state`=IDLE, `ptr`=0, `checksum`=0x00, `load_done`=0, `load_ready`=0, `cpu_n_rst`=0, all `mem`=0x00, so `opecode`/`imm`=0.
- `load_ready`, `cpu_n_rst` and `state_o` decode directly from the state register.
  - `load_ready` rises in the cycle after the `load_start` edge.
  - `cpu_n_rst` rises in the cycle after the edge that accepts the 16th word.
- `load_done` is registered. It is high for exactly the one cycle following the 16th accept, coincident with the first RUN cycle.
- Write latency: a word accepted at edge N is visible on the read port from cycle N+1.
- Load throughput: one word per cycle. A minimum load takes 16 cycles after entering LOAD.
- `rst` asserted in any state, including mid-load, returns to reset values at the next edge and overrides every other input.

## Test plan
- **Reset:** assert `rst` 2 cycles with `addr`=5 → `opecode`=0, `imm`=0, `cpu_n_rst`=0, `load_ready`=0, `checksum`=0x00, `state_o`=0.
- **Full load:**
  - Stimulus: pulse `load_start`, then stream words 0x31, 0x02, …, 0xF0 (16 words) back-to-back.
  - Required: `load_done` high for one cycle with `state_o`=2 and `cpu_n_rst`=1 on the next cycle; sweeping `addr` 0..15 returns each written word; `checksum` equals the mod-256 sum.
- **Gapped load:** de-assert `load_valid` on alternate cycles → still exactly 16 writes; `ptr` does not advance on idle cycles; same final contents.
- **Restart mid-load:**
  - Stimulus: after 5 words, raise `load_start` together with `load_valid`=1 and `load_data`=0xAA.
  - Required: 0xAA is not written; `checksum`=0x00; the next accepted word lands at address 0.
- **Reload from RUN:** in RUN pulse `load_start` → `cpu_n_rst`=0 the next cycle, `state_o`=1, `load_ready`=1.
- **Run without load, and priority:**
  - Pulse `run` in IDLE → `cpu_n_rst`=1, all fetches return 0x00.
  - `run` and `load_start` together in IDLE → LOAD.
  - `rst` mid-load → all words return 0x00.
